// File: rtl/bt656_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt656_pkg
// Description : Shared types and helpers for the BT.656 receiver: FSM state
//               encoding, XY bit positions (8-bit MSB window), 4:2:2 phase
//               codes and the XY protection-bit encode/check functions.
// Revision    : 1.0 - initial release
// ============================================================================
package bt656_pkg;

  typedef enum logic [2:0] {
    ST_BLANK  = 3'd0,
    ST_TRS1   = 3'd1,
    ST_TRS2   = 3'd2,
    ST_TRS3   = 3'd3,
    ST_ACTIVE = 3'd4
  } state_t;

  // Bit positions inside the 8 MSBs of an XY word
  localparam int c_xy_f = 6;
  localparam int c_xy_v = 5;
  localparam int c_xy_h = 4;

  // Position of a word inside the Cb,Y0,Cr,Y1 quad
  localparam logic [1:0] c_ph_cb = 2'd0;
  localparam logic [1:0] c_ph_y0 = 2'd1;
  localparam logic [1:0] c_ph_cr = 2'd2;
  localparam logic [1:0] c_ph_y1 = 2'd3;

  // Build the legal XY word for a given F/V/H combination
  function automatic logic [7:0] xy_encode(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Exact check: returns {valid, F, V, H}
  function automatic logic [3:0] xy_check(input logic [7:0] xy);
    logic f, v, h;
    f = xy[c_xy_f];
    v = xy[c_xy_v];
    h = xy[c_xy_h];
    return {(xy == xy_encode(f, v, h)), f, v, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bt656_xy_decode.sv
`default_nettype none
// ============================================================================
// Module      : bt656_xy_decode
// Description : Combinational XY word check. Build option BT656_ECC_EN
//               enables single-bit correction over the 8 XY MSBs (fixed bit
//               included); otherwise any deviation is flagged invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module bt656_xy_decode (
  input  logic [7:0] xy,
  output logic       valid,
  output logic       f,
  output logic       v,
  output logic       h
);
  import bt656_pkg::*;

`ifdef BT656_ECC_EN
  logic [7:0] w_code;
  logic [2:0] w_idx;

  // Nearest-codeword search: distance 0 is clean, distance 1 is corrected.
  // The code has minimum distance 4, so at most one candidate can match.
  always_comb begin
    valid     = 1'b0;
    {f, v, h} = xy[c_xy_f -: 3];
    w_code    = '0;
    w_idx     = '0;
    for (int i = 0; i < 8; i++) begin
      w_idx  = 3'(i);
      w_code = xy_encode(w_idx[2], w_idx[1], w_idx[0]);
      if ($countones(w_code ^ xy) <= 1) begin
        valid     = 1'b1;
        {f, v, h} = w_idx;
      end
    end
  end
`else
  assign {valid, f, v, h} = xy_check(xy);
`endif

endmodule
`default_nettype wire

// File: rtl/bt656_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : bt656_rx_param
// Description : Parametrised ITU-R BT.656 receiver. Finds TRS codes, checks
//               XY words, tracks sync lock and turns the 4:2:2 stream into
//               one 4:4:4 pixel per Y sample with position and sync markers.
//               Build option: BT656_ECC_EN (XY single-bit correction).
// Revision    : 1.0 - initial release
// ============================================================================
module bt656_rx_param #(
  parameter int DW      = 8,
  parameter int LINE_W  = 10,
  parameter int PIX_W   = 11,
  parameter int LOCK_N  = 4,
  parameter int GAP_MAX = 2047
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     din,
  output logic              pix_valid,
  output logic [DW-1:0]     y,
  output logic [DW-1:0]     cb,
  output logic [DW-1:0]     cr,
  output logic [PIX_W-1:0]  pix_x,
  output logic [LINE_W-1:0] line,
  output logic              field,
  output logic              vblank,
  output logic              hblank,
  output logic              sof,
  output logic              sol,
  output logic [PIX_W-1:0]  act_width,
  output logic              sync_lock,
  output logic              trs_err
);
  import bt656_pkg::*;

  localparam int                 c_gap_w   = $clog2(GAP_MAX + 1);
  localparam logic [c_gap_w-1:0] c_gap_max = c_gap_w'(GAP_MAX);
  localparam logic [3:0]         c_lock_n  = 4'(LOCK_N);
  localparam logic [DW-1:0]      c_ones    = '1;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_phase;
  logic [DW-1:0]      r_cb, r_y0;
  logic [3:0]         r_lock_cnt, w_lock_inc;
  logic [c_gap_w-1:0] r_gap;
  logic               r_after_vb, r_in_line;
  logic               w_ones, w_zero, w_trs3, w_act_word;
  logic               w_xy_valid, w_f, w_v, w_h, w_xy_ok, w_sav, w_eav;

  bt656_xy_decode u_xy (
    .xy    (din[DW-1 -: 8]),
    .valid (w_xy_valid),
    .f     (w_f),
    .v     (w_v),
    .h     (w_h)
  );

  assign w_ones     = (din == c_ones);
  assign w_zero     = (din == '0);
  assign w_trs3     = (r_state == ST_TRS3);
  assign w_xy_ok    = w_trs3 & w_xy_valid;
  assign w_sav      = w_xy_ok & ~w_v & ~w_h;
  assign w_eav      = w_xy_ok & w_h;
  assign w_act_word = (r_state == ST_ACTIVE) & ~w_ones;
  assign w_lock_inc = (r_lock_cnt == c_lock_n) ? r_lock_cnt : r_lock_cnt + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BLANK;
    else        r_state <= w_state_nxt;
  end

  // TRS preamble search; only a clean active-video SAV opens a line
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BLANK:  if (w_ones) w_state_nxt = ST_TRS1;
      ST_TRS1:   w_state_nxt = w_zero ? ST_TRS2 : ST_BLANK;
      ST_TRS2:   w_state_nxt = w_zero ? ST_TRS3 : ST_BLANK;
      ST_TRS3:   w_state_nxt = w_sav ? ST_ACTIVE : ST_BLANK;
      ST_ACTIVE: if (w_ones) w_state_nxt = ST_TRS1;
      default:   w_state_nxt = ST_BLANK;
    endcase
  end

  // Quad assembly: hold Cb/Y0, launch a pixel one clock after Cr and after Y1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_cb      <= '0;
      r_y0      <= '0;
      pix_valid <= 1'b0;
      y         <= '0;
      cb        <= '0;
      cr        <= '0;
    end else begin
      pix_valid <= 1'b0;
      r_phase   <= w_act_word ? r_phase + 2'd1 : 2'd0;
      if (w_act_word) begin
        case (r_phase)
          c_ph_cb: r_cb <= din;
          c_ph_y0: r_y0 <= din;
          c_ph_cr: begin
            cb        <= r_cb;
            y         <= r_y0;
            cr        <= din;
            pix_valid <= sync_lock;
          end
          c_ph_y1: begin
            y         <= din;
            pix_valid <= sync_lock;
          end
        endcase
      end
    end
  end

  // Pixel index within the line and width of the last completed line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x     <= '0;
      act_width <= '0;
      r_in_line <= 1'b0;
    end else begin
      if (w_sav)          pix_x <= '0;
      else if (pix_valid) pix_x <= pix_x + 1'b1;
      if (w_trs3)               r_in_line <= w_sav;
      if (w_eav && r_in_line)   act_width <= pix_x;
    end
  end

  // Timing flags, line counter and start-of-frame/line markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field      <= 1'b0;
      vblank     <= 1'b0;
      hblank     <= 1'b0;
      line       <= '0;
      sof        <= 1'b0;
      sol        <= 1'b0;
      trs_err    <= 1'b0;
      r_after_vb <= 1'b0;
    end else begin
      sof     <= 1'b0;
      sol     <= 1'b0;
      trs_err <= w_trs3 & ~w_xy_valid;
      if (w_xy_ok) begin
        field  <= w_f;
        vblank <= w_v;
        hblank <= w_h;
        if (w_v) begin
          r_after_vb <= 1'b1;
        end else if (!w_h) begin
          sol <= 1'b1;
          if (r_after_vb) begin
            line       <= '0;
            sof        <= 1'b1;
            r_after_vb <= 1'b0;
          end else if (line != '1) begin
            line <= line + 1'b1;
          end
        end
      end
    end
  end

  // Lock tracking: consecutive valid XYs build lock, errors or a TRS gap drop it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
      r_gap      <= '0;
      sync_lock  <= 1'b0;
    end else if (w_trs3) begin
      r_gap <= '0;
      if (w_xy_valid) begin
        r_lock_cnt <= w_lock_inc;
        sync_lock  <= (w_lock_inc == c_lock_n);
      end else begin
        r_lock_cnt <= '0;
        sync_lock  <= 1'b0;
      end
    end else if (r_gap == c_gap_max) begin
      r_lock_cnt <= '0;
      sync_lock  <= 1'b0;
    end else begin
      r_gap <= r_gap + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bt656_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bt656_rx_param
// Description : Self-checking bench. Drives an 8-bit and a 10-bit receiver
//               with the same BT.656 stream (10-bit copy gets random LSBs)
//               and checks both against a stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt656_rx_param;
  localparam int LOCK_N  = 4;
  localparam int GAP_MAX = 2047;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din8;
  logic [9:0] din10;

  logic pv8, fld8, vb8, hb8, sof8, sol8, lock8, err8;
  logic [7:0] y8, cb8, cr8;
  logic [10:0] px8, aw8;
  logic [9:0] ln8;
  logic pv10, fld10, vb10, hb10, sof10, sol10, lock10, err10;
  logic [9:0] y10, cb10, cr10;
  logic [10:0] px10, aw10;
  logic [9:0] ln10;

  bt656_rx_param #(.DW(8), .LINE_W(10), .PIX_W(11), .LOCK_N(LOCK_N), .GAP_MAX(GAP_MAX)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .pix_valid(pv8), .y(y8), .cb(cb8), .cr(cr8),
    .pix_x(px8), .line(ln8), .field(fld8), .vblank(vb8), .hblank(hb8), .sof(sof8), .sol(sol8),
    .act_width(aw8), .sync_lock(lock8), .trs_err(err8));

  bt656_rx_param #(.DW(10), .LINE_W(10), .PIX_W(11), .LOCK_N(LOCK_N), .GAP_MAX(GAP_MAX)) dut10 (
    .clk(clk), .rst_n(rst_n), .din(din10), .pix_valid(pv10), .y(y10), .cb(cb10), .cr(cr10),
    .pix_x(px10), .line(ln10), .field(fld10), .vblank(vb10), .hblank(hb10), .sof(sof10), .sol(sol10),
    .act_width(aw10), .sync_lock(lock10), .trs_err(err10));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [9:0]  y;
    logic [9:0]  cb;
    logic [9:0]  cr;
    logic [31:0] x;
  } pix_t;

  // Reference model state
  pix_t       q[$];
  int         m_cnt;
  bit         m_lock;
  logic       m_f, m_v, m_h;
  logic [9:0] m_line;
  bit         m_after_vb, m_in_line;
  int         m_px;
  logic [10:0] m_aw;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xy_word(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Distance of a received XY to the nearest legal word decides its fate
  function automatic bit xy_ok(input logic [7:0] w, output logic [2:0] fvh);
    int best, d;
    logic [2:0] k3;
    best = 9;
    fvh  = '0;
    for (int k = 0; k < 8; k++) begin
      k3 = 3'(k);
      d  = $countones(xy_word(k3[2], k3[1], k3[0]) ^ w);
      if (d < best) begin
        best = d;
        fvh  = k3;
      end
    end
`ifdef BT656_ECC_EN
    return best <= 1;
`else
    return best == 0;
`endif
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_lock = 0; m_f = 0; m_v = 0; m_h = 0; m_line = '0;
    m_after_vb = 0; m_in_line = 0; m_px = 0; m_aw = '0;
    q.delete();
  endtask

  task automatic put(input logic [7:0] w);
    din8  = w;
    din10 = {w, (w == 8'hFF) ? 2'b11 : (w == 8'h00) ? 2'b00 : 2'($urandom)};
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) put(8'($urandom_range(1, 254)));
  endtask

  task automatic push(input logic [9:0] yv, input logic [9:0] cbv, input logic [9:0] crv);
    if (m_lock) begin
      q.push_back('{y: yv, cb: cbv, cr: crv, x: 32'(m_px)});
      m_px++;
    end
  endtask

  task automatic quad(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
    logic [9:0] c, a, r;
    put(w0); c = din10;
    put(w1); a = din10;
    put(w2); r = din10;
    push(a, c, r);
    put(w3);
    push(din10, c, r);
  endtask

  task automatic rquad();
    quad(8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)),
         8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)));
  endtask

  // Full TRS followed by model update and checks of everything an XY affects
  task automatic trs(input logic [7:0] w);
    logic [2:0] fvh;
    bit ok, sav, e_sof, e_sol;
    e_sof = 0; e_sol = 0; sav = 0;
    put(8'hFF); put(8'h00); put(8'h00); put(w);
    ok = xy_ok(w, fvh);
    if (ok) begin
      if (m_cnt < LOCK_N) m_cnt++;
      {m_f, m_v, m_h} = fvh;
      if (fvh[1]) m_after_vb = 1;
      else if (!fvh[0]) begin
        e_sol = 1;
        if (m_after_vb) begin
          m_line = '0; e_sof = 1; m_after_vb = 0;
        end else if (m_line != 10'h3FF) m_line++;
      end
      if (fvh[0] && m_in_line) m_aw = 11'(m_px);
      sav = !fvh[1] && !fvh[0];
    end else begin
      m_cnt = 0;
    end
    m_in_line = sav;
    if (sav) m_px = 0;
    m_lock = (m_cnt >= LOCK_N);
    chk("trs_err", {err8, err10}, {2{!ok}});
    chk("flags", {fld8, vb8, hb8, fld10, vb10, hb10}, {2{m_f, m_v, m_h}});
    chk("sof_sol", {sof8, sol8, sof10, sol10}, {2{e_sof, e_sol}});
    chk("line", {ln8, ln10}, {2{m_line}});
    chk("sync_lock", {lock8, lock10}, {2{m_lock}});
    chk("act_width", {aw8, aw10}, {2{m_aw}});
    if (sav) chk("pix_x_sav", {px8, px10}, 22'd0);
  endtask

  // Active line: SAV, nq quads, 'extra' words of a truncated quad, EAV, blanking
  task automatic line_v0(input logic f, input int nq, input int extra);
    trs(xy_word(f, 1'b0, 1'b0));
    for (int i = 0; i < nq; i++) rquad();
    for (int i = 0; i < extra; i++) put(8'($urandom_range(1, 254)));
    trs(xy_word(f, 1'b0, 1'b1));
    chk("line_drained", 32'(q.size()), 32'd0);
    blank($urandom_range(8, 15));
  endtask

  task automatic vline(input logic f);
    trs(xy_word(f, 1'b1, 1'b1));
    blank(4);
    trs(xy_word(f, 1'b1, 1'b0));
    blank(4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dw8"}, {pv8, y8, cb8, cr8, px8, ln8, fld8, vb8, hb8, sof8, sol8, aw8, lock8, err8}, '0);
    chk({tag, "_dw10"}, {pv10, y10, cb10, cr10, px10, ln10, fld10, vb10, hb10, sof10, sol10, aw10, lock10, err10}, '0);
  endtask

  // Every emitted pixel must be the next one the model predicted
  always @(negedge clk) begin
    if (rst_n && (pv8 || pv10)) begin
      if (q.size() == 0) begin
        chk("spurious_pixel", {pv8, pv10}, 2'b00);
      end else begin
        pix_t e;
        e = q.pop_front();
        chk("pixel_dw8", {pv8, cb8, y8, cr8, px8}, {1'b1, e.cb[9:2], e.y[9:2], e.cr[9:2], 11'(e.x)});
        chk("pixel_dw10", {pv10, cb10, y10, cr10, px10}, {1'b1, e.cb, e.y, e.cr, 11'(e.x)});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] c, a, r;
    din8 = '0; din10 = '0;
    m_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    blank(5);

    // Four clean 720-pixel lines; lock arrives with the 4th valid XY
    for (int i = 0; i < 4; i++) line_v0(1'b0, 360, 0);

    // Directed quad
    trs(xy_word(1'b0, 1'b0, 1'b0));
    put(8'h10); c = din10;
    put(8'h20); a = din10;
    put(8'h30); r = din10;
    push(a, c, r);
    chk("quad_first", {pv8, cb8, y8, cr8}, {1'b1, 8'h10, 8'h20, 8'h30});
    put(8'h40);
    push(din10, c, r);
    chk("quad_second", {pv8, cb8, y8, cr8}, {1'b1, 8'h10, 8'h40, 8'h30});
    for (int i = 0; i < 6; i++) rquad();
    trs(xy_word(1'b0, 1'b0, 1'b1));
    blank(10);

    // Vertical blanking then active lines, for both fields
    for (int f = 0; f < 2; f++) begin
      repeat (20) vline(1'(f));
      line_v0(1'(f), $urandom_range(2, 20), 0);
      line_v0(1'(f), $urandom_range(2, 20), $urandom_range(1, 2));
    end

    // Random active lines
    repeat (8) line_v0(1'($urandom), $urandom_range(2, 40), $urandom_range(0, 2));

    // Corrupted XY (0x9D with bit 2 flipped)
    trs(xy_word(1'b1, 1'b1, 1'b0));
    blank(5);
    trs(8'h99);
    blank(5);
    repeat (3) line_v0(1'b0, $urandom_range(2, 20), 0);

    // TRS gap: lock survives GAP_MAX clocks, drops one clock later
    trs(xy_word(1'b0, 1'b1, 1'b1));
    blank(GAP_MAX);
    chk("gap_hold", {lock8, lock10}, {2{m_lock}});
    blank(1);
    chk("gap_drop", {lock8, lock10}, 2'b00);
    m_cnt = 0;
    m_lock = 0;
    repeat (3) line_v0(1'b1, $urandom_range(2, 20), $urandom_range(0, 2));

    // Asynchronous reset in the middle of a locked line
    trs(xy_word(1'b0, 1'b0, 1'b0));
    repeat (5) rquad();
    put(8'h55);
    rst_n = 1'b0;
    #2;
    chk_reset("mid_line_reset");
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    blank(5);
    repeat (3) line_v0(1'($urandom), $urandom_range(2, 30), 0);

    chk("final_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
